// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: round-robin arbiter sharing one APB4 master port between NUM_REQ requesters,
// with SETUP/ACCESS sequencing, pready wait states and an optional hung-slave timeout.
module apb_master_arbiter #(
   parameter int NUM_REQ    = 2,
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 16
) (
   input  logic                            pclk,
   input  logic                            presetn,
   input  logic [NUM_REQ-1:0]              req_valid,
   input  logic [NUM_REQ-1:0]              req_write,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
   input  logic [NUM_REQ*DATA_WIDTH/8-1:0] req_strb,
   output logic [NUM_REQ-1:0]              req_done,
   output logic [DATA_WIDTH-1:0]           req_rdata,
   output logic                            req_slverr,
   output logic                            psel,
   output logic                            penable,
   output logic                            pwrite,
   output logic [ADDR_WIDTH-1:0]           paddr,
   output logic [DATA_WIDTH-1:0]           pwdata,
   output logic [DATA_WIDTH/8-1:0]         pstrb,
   input  logic [DATA_WIDTH-1:0]           prdata,
   input  logic                            pready,
   input  logic                            pslverr
);
   localparam int SW = DATA_WIDTH / 8;
   localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
   localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

   state_t               state_q, state_d;
   logic [IW-1:0]        ptr_q, ptr_d, gnt_q, gnt_d, sel, lo, hi;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
   logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
   logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d, rdata_q, rdata_d;
   logic [SW-1:0]        pstrb_q, pstrb_d;
   logic [NUM_REQ-1:0]   done_q, done_d, elig;
   logic                 slverr_q, slverr_d, any_req, hi_v, tmo, fin;

   // The requester completing this cycle is masked so it may drop valid in the same cycle.
   assign elig = req_valid & ~done_q;
   assign tmo  = (TIMEOUT != 0) && !pready && (cnt_q == TO_LAST);
   assign fin  = pready || tmo;

   always_comb begin
      any_req = 1'b0;
      hi_v    = 1'b0;
      lo      = '0;
      hi      = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (elig[i]) begin
            any_req = 1'b1;
            lo      = IW'(i);
            if (i > int'(ptr_q)) begin
               hi_v = 1'b1;
               hi   = IW'(i);
            end
         end
      end
      sel = hi_v ? hi : lo;
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state_q   <= IDLE;
         ptr_q     <= IW'(NUM_REQ - 1);
         gnt_q     <= '0;
         cnt_q     <= '0;
         psel_q    <= 1'b0;
         penable_q <= 1'b0;
         pwrite_q  <= 1'b0;
         paddr_q   <= '0;
         pwdata_q  <= '0;
         pstrb_q   <= '0;
         done_q    <= '0;
         rdata_q   <= '0;
         slverr_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         gnt_q     <= gnt_d;
         cnt_q     <= cnt_d;
         psel_q    <= psel_d;
         penable_q <= penable_d;
         pwrite_q  <= pwrite_d;
         paddr_q   <= paddr_d;
         pwdata_q  <= pwdata_d;
         pstrb_q   <= pstrb_d;
         done_q    <= done_d;
         rdata_q   <= rdata_d;
         slverr_q  <= slverr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = any_req ? SETUP : IDLE;
         SETUP:   state_d = ACCESS;
         ACCESS:  state_d = fin ? IDLE : ACCESS;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ptr_d     = ptr_q;
      gnt_d     = gnt_q;
      cnt_d     = '0;
      psel_d    = psel_q;
      penable_d = penable_q;
      pwrite_d  = pwrite_q;
      paddr_d   = paddr_q;
      pwdata_d  = pwdata_q;
      pstrb_d   = pstrb_q;
      done_d    = '0;
      rdata_d   = '0;
      slverr_d  = 1'b0;
      case (state_q)
         IDLE: if (any_req) begin
            ptr_d    = sel;
            gnt_d    = sel;
            psel_d   = 1'b1;
            pwrite_d = req_write[sel];
            paddr_d  = req_addr[sel*ADDR_WIDTH +: ADDR_WIDTH];
            pwdata_d = req_write[sel] ? req_wdata[sel*DATA_WIDTH +: DATA_WIDTH] : '0;
            pstrb_d  = req_write[sel] ? req_strb[sel*SW +: SW] : '0;
         end
         SETUP: penable_d = 1'b1;
         ACCESS: if (fin) begin
            psel_d        = 1'b0;
            penable_d     = 1'b0;
            done_d[gnt_q] = 1'b1;
            rdata_d       = (pready && !pwrite_q) ? prdata : '0;
            slverr_d      = pready ? pslverr : 1'b1;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
         default: ;
      endcase
   end

   assign req_done   = done_q;
   assign req_rdata  = rdata_q;
   assign req_slverr = slverr_q;
   assign psel       = psel_q;
   assign penable    = penable_q;
   assign pwrite     = pwrite_q;
   assign paddr      = paddr_q;
   assign pwdata     = pwdata_q;
   assign pstrb      = pstrb_q;
endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb_apb_master_arbiter: directed checks of arbitration order, APB phase timing, wait states,
// slave error, timeout and asynchronous reset for apb_master_arbiter (2 requesters).
module tb_apb_master_arbiter;
   logic        pclk = 1'b0;
   logic        presetn;
   logic [1:0]  req_valid, req_write, req_done;
   logic [15:0] req_addr;
   logic [63:0] req_wdata;
   logic [7:0]  req_strb;
   logic [31:0] req_rdata, pwdata, prdata;
   logic        req_slverr, psel, penable, pwrite, pready, pslverr;
   logic [7:0]  paddr;
   logic [3:0]  pstrb;
   int          n_chk = 0;
   int          n_err = 0;

   apb_master_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(8), .DATA_WIDTH(32), .TIMEOUT(16)) dut (
      .pclk(pclk), .presetn(presetn),
      .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_strb(req_strb),
      .req_done(req_done), .req_rdata(req_rdata), .req_slverr(req_slverr),
      .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
      .pwdata(pwdata), .pstrb(pstrb),
      .prdata(prdata), .pready(pready), .pslverr(pslverr)
   );

   always #5 pclk = ~pclk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   initial begin
      presetn   = 1'b0;
      req_valid = '0;
      req_write = '0;
      req_addr  = '0;
      req_wdata = '0;
      req_strb  = '0;
      prdata    = '0;
      pready    = 1'b0;
      pslverr   = 1'b0;
      repeat (2) tick();
      chk("rst_psel", psel, 0);
      chk("rst_penable", penable, 0);
      chk("rst_done", req_done, 0);
      chk("rst_rdata", req_rdata, 0);
      chk("rst_slverr", req_slverr, 0);
      chk("rst_paddr", paddr, 0);
      presetn = 1'b1;
      tick();

      // single write from requester 0, zero wait states
      req_valid = 2'b01;
      req_write = 2'b01;
      req_addr[7:0]   = 8'h10;
      req_wdata[31:0] = 32'hDEADBEEF;
      req_strb[3:0]   = 4'hF;
      pready = 1'b1;
      tick();
      chk("wr_setup_psel", psel, 1);
      chk("wr_setup_penable", penable, 0);
      chk("wr_paddr", paddr, 8'h10);
      chk("wr_pwdata", pwdata, 32'hDEADBEEF);
      chk("wr_pstrb", pstrb, 4'hF);
      chk("wr_pwrite", pwrite, 1);
      tick();
      chk("wr_access_penable", penable, 1);
      chk("wr_access_psel", psel, 1);
      tick();
      chk("wr_done", req_done, 2'b01);
      chk("wr_done_psel", psel, 0);
      chk("wr_done_slverr", req_slverr, 0);
      req_valid = '0;
      tick();
      chk("wr_done_clear", req_done, 0);
      chk("wr_idle_psel", psel, 0);

      // read from requester 1 with three wait states
      req_valid = 2'b10;
      req_write = 2'b00;
      req_addr[15:8]   = 8'h20;
      req_wdata[63:32] = 32'hAAAAAAAA;
      req_strb[7:4]    = 4'hF;
      pready = 1'b0;
      tick();
      chk("rd_psel", psel, 1);
      chk("rd_paddr", paddr, 8'h20);
      chk("rd_pstrb", pstrb, 0);
      chk("rd_pwdata", pwdata, 0);
      chk("rd_pwrite", pwrite, 0);
      tick();
      for (int i = 0; i < 3; i++) begin
         chk("rd_wait_penable", penable, 1);
         chk("rd_wait_paddr", paddr, 8'h20);
         chk("rd_wait_done", req_done, 0);
         tick();
      end
      chk("rd_wait_hold", penable, 1);
      pready = 1'b1;
      prdata = 32'h12345678;
      tick();
      chk("rd_done", req_done, 2'b10);
      chk("rd_rdata", req_rdata, 32'h12345678);
      chk("rd_slverr", req_slverr, 0);
      req_valid = '0;
      pready = 1'b0;
      tick();
      chk("rd_rdata_clear", req_rdata, 0);

      // contention: both requesters valid for four transfers
      pready    = 1'b1;
      req_valid = 2'b11;
      req_write = 2'b11;
      req_addr  = {8'h31, 8'h30};
      for (int t = 0; t < 4; t++) begin
         tick();
         chk("cont_psel", psel, 1);
         chk("cont_paddr", paddr, (t % 2) ? 8'h31 : 8'h30);
         tick();
         chk("cont_penable", penable, 1);
         tick();
         chk("cont_done", req_done, (t % 2) ? 2'b10 : 2'b01);
         chk("cont_gap", psel, 0);
         if (t == 3) req_valid = '0;
      end

      // slave error, then a clean transfer
      req_valid = 2'b01;
      req_write = 2'b11;
      req_addr  = {8'h40, 8'hFF};
      pslverr   = 1'b1;
      tick();
      chk("err_paddr", paddr, 8'hFF);
      tick();
      tick();
      chk("err_done", req_done, 2'b01);
      chk("err_slverr", req_slverr, 1);
      req_valid = 2'b10;
      pslverr   = 1'b0;
      tick();
      chk("err_next_psel", psel, 1);
      chk("err_slverr_clear", req_slverr, 0);
      chk("err_next_paddr", paddr, 8'h40);
      tick();
      tick();
      chk("err_next_done", req_done, 2'b10);
      chk("err_next_slverr", req_slverr, 0);
      req_valid = '0;

      // timeout on a hung slave
      req_valid = 2'b01;
      req_write = 2'b00;
      req_addr[7:0] = 8'h50;
      pready = 1'b0;
      prdata = 32'hCAFEF00D;
      tick();
      chk("to_psel", psel, 1);
      tick();
      repeat (15) tick();
      chk("to_still_access", {psel, penable}, 2'b11);
      chk("to_no_done", req_done, 0);
      tick();
      chk("to_done", req_done, 2'b01);
      chk("to_slverr", req_slverr, 1);
      chk("to_rdata", req_rdata, 0);
      chk("to_psel_low", psel, 0);
      chk("to_penable_low", penable, 0);
      req_valid = '0;

      // asynchronous reset during a wait state
      req_valid = 2'b10;
      req_addr  = {8'h61, 8'h60};
      tick();
      chk("rr_paddr", paddr, 8'h61);
      tick();
      tick();
      chk("rr_in_access", penable, 1);
      presetn = 1'b0;
      #1;
      chk("rr_psel", psel, 0);
      chk("rr_penable", penable, 0);
      chk("rr_done", req_done, 0);
      req_valid = 2'b11;
      pready = 1'b1;
      tick();
      chk("rr_hold_done", req_done, 0);
      presetn = 1'b1;
      tick();
      chk("rr_regrant_psel", psel, 1);
      chk("rr_regrant_paddr", paddr, 8'h60);
      tick();
      tick();
      chk("rr_regrant_done", req_done, 2'b01);
      req_valid = '0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
